// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: receiver states, scan-code constants
// and the special (non-ASCII) output codes for navigation keys.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Prefix and modifier scan codes (set 2)
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;

  // Extended (E0-prefixed) scan codes that produce output
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_HOME   = 8'h6C;
  localparam logic [7:0] SC_END    = 8'h69;
  localparam logic [7:0] SC_DEL    = 8'h71;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  // Output codes for the extended keys
  localparam logic [7:0] KEY_UP    = 8'h80;
  localparam logic [7:0] KEY_DOWN  = 8'h81;
  localparam logic [7:0] KEY_LEFT  = 8'h82;
  localparam logic [7:0] KEY_RIGHT = 8'h83;
  localparam logic [7:0] KEY_HOME  = 8'h84;
  localparam logic [7:0] KEY_END   = 8'h85;
  localparam logic [7:0] KEY_DEL   = 8'h7F;
  localparam logic [7:0] KEY_CR    = 8'h0D;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, samples data on falling
// edges of the keyboard clock, checks start/parity/stop and drops partial
// frames that stall longer than the timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int TIMEOUT_US = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       stb,
  output logic [7:0] rx_byte,
  output logic       rx_error
);

  localparam int TO_LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [1:0]      clk_sync, data_sync;
  logic            clk_old;
  rx_state_t       state, state_nx;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par;
  logic [TO_W-1:0] to_cnt;
  logic            fall, sdata, timeout, frame_ok, err_nx, ok_nx;

  assign fall     = clk_old & ~clk_sync[1];
  assign sdata    = data_sync[1];
  // A falling edge in the expiry cycle wins over the timeout
  assign timeout  = (state != RX_IDLE) && (to_cnt == TO_W'(TO_LIMIT)) && !fall;
  // Odd parity: data bits plus parity bit must XOR to 1
  assign frame_ok = sdata & (^{shreg, par});
  assign rx_byte  = shreg;

  // Two-flop synchronizers plus the previous clock sample for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_old   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_old   <= clk_sync[1];
    end
  end

  // Receiver state register
  always_ff @(posedge clock) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_nx;
  end

  // Next-state: advance one step per sampled bit, bail to IDLE on timeout
  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = RX_IDLE;
    end else if (fall) begin
      case (state)
        RX_IDLE:   if (!sdata) state_nx = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_nx = RX_PARITY;
        RX_PARITY: state_nx = RX_STOP;
        RX_STOP:   state_nx = RX_IDLE;
        default:   state_nx = RX_IDLE;
      endcase
    end
  end

  // Outputs: accept/reject decisions made at the stop-bit sample
  always_comb begin
    err_nx = timeout;
    ok_nx  = 1'b0;
    if (fall) begin
      if (state == RX_IDLE && sdata)  err_nx = 1'b1;
      if (state == RX_STOP) begin
        ok_nx  = frame_ok;
        err_nx = !frame_ok;
      end
    end
  end

  // Bit datapath, timeout counter and registered output pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      par      <= 1'b0;
      to_cnt   <= '0;
      stb      <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      stb      <= ok_nx;
      rx_error <= err_nx;
      if (fall)                         to_cnt <= '0;
      else if (to_cnt != TO_W'(TO_LIMIT)) to_cnt <= to_cnt + 1'b1;
      if (timeout) begin
        bit_cnt <= 3'd0;
      end else if (fall) begin
        case (state)
          RX_IDLE:   bit_cnt <= 3'd0;
          RX_DATA: begin
            shreg   <= {sdata, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_PARITY: par <= sdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: receiver plus scan-code decoder that tracks the
// E0/F0 prefixes and shift/ctrl modifiers and emits ASCII on each make.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int TIMEOUT_US = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       kdone,
  output logic [7:0] ascii,
  output logic       rx_error
);

  logic       rx_stb;
  logic [7:0] rx_byte;
  logic       ext, brk, shift, ctrl;
  logic [7:0] tbl, xlat;
  logic       emit, is_letter;

  ps2_rx #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) u_rx (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .stb      (rx_stb),
    .rx_byte  (rx_byte),
    .rx_error (rx_error)
  );

  // 128-entry translation table, {plain, shifted}; 00h means unmapped
  function automatic logic [7:0] key_lookup(input logic [6:0] code, input logic shifted);
    logic [15:0] ps;
    case (code)
      7'h1C: ps = "aA";  7'h32: ps = "bB";  7'h21: ps = "cC";  7'h23: ps = "dD";
      7'h24: ps = "eE";  7'h2B: ps = "fF";  7'h34: ps = "gG";  7'h33: ps = "hH";
      7'h43: ps = "iI";  7'h3B: ps = "jJ";  7'h42: ps = "kK";  7'h4B: ps = "lL";
      7'h3A: ps = "mM";  7'h31: ps = "nN";  7'h44: ps = "oO";  7'h4D: ps = "pP";
      7'h15: ps = "qQ";  7'h2D: ps = "rR";  7'h1B: ps = "sS";  7'h2C: ps = "tT";
      7'h3C: ps = "uU";  7'h2A: ps = "vV";  7'h1D: ps = "wW";  7'h22: ps = "xX";
      7'h35: ps = "yY";  7'h1A: ps = "zZ";
      7'h16: ps = "1!";  7'h1E: ps = "2@";  7'h26: ps = "3#";  7'h25: ps = "4$";
      7'h2E: ps = "5%";  7'h36: ps = "6^";  7'h3D: ps = "7&";  7'h3E: ps = "8*";
      7'h46: ps = "9(";  7'h45: ps = "0)";
      7'h0E: ps = 16'h607E;  // ` ~
      7'h4E: ps = "-_";  7'h55: ps = "=+";  7'h54: ps = "[{";  7'h5B: ps = "]}";
      7'h5D: ps = "\\|"; 7'h4C: ps = ";:";  7'h52: ps = "'\""; 7'h41: ps = ",<";
      7'h49: ps = ".>";  7'h4A: ps = "/?";
      7'h29: ps = 16'h2020;  // space
      7'h5A: ps = 16'h0D0D;  // enter
      7'h66: ps = 16'h0808;  // backspace
      7'h76: ps = 16'h1B1B;  // escape
      7'h0D: ps = 16'h0909;  // tab
      default: ps = 16'h0000;
    endcase
    return shifted ? ps[7:0] : ps[15:8];
  endfunction

  assign tbl       = key_lookup(rx_byte[6:0], shift);
  assign is_letter = (tbl >= 8'h61 && tbl <= 8'h7A) || (tbl >= 8'h41 && tbl <= 8'h5A);

  // Translate the received make code into an output character, if any
  always_comb begin
    emit = 1'b0;
    xlat = 8'h00;
    if (ext) begin
      emit = 1'b1;
      case (rx_byte)
        SC_UP:    xlat = KEY_UP;
        SC_DOWN:  xlat = KEY_DOWN;
        SC_LEFT:  xlat = KEY_LEFT;
        SC_RIGHT: xlat = KEY_RIGHT;
        SC_HOME:  xlat = KEY_HOME;
        SC_END:   xlat = KEY_END;
        SC_DEL:   xlat = KEY_DEL;
        SC_ENTER: xlat = KEY_CR;
        default:  emit = 1'b0;
      endcase
    end else if (!rx_byte[7]) begin
      emit = (tbl != 8'h00);
      xlat = (ctrl && is_letter) ? (tbl & 8'h1F) : tbl;
    end
  end

  // Prefix/modifier tracking and the registered kdone/ascii outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      ext   <= 1'b0;
      brk   <= 1'b0;
      shift <= 1'b0;
      ctrl  <= 1'b0;
      kdone <= 1'b0;
      ascii <= 8'h00;
    end else begin
      kdone <= 1'b0;
      if (rx_stb) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT) begin
            shift <= ~brk;
          end else if (rx_byte == SC_CTRL) begin
            ctrl <= ~brk;
          end else if (!brk && emit) begin
            kdone <= 1'b1;
            ascii <= xlat;
          end
        end
      end
    end
  end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter CLK_HZ, default 25000000, system clock frequency used to derive the PS/2 timeout.
REQ-002 Parameter TIMEOUT_US, default 100, idle time in microseconds after which a partial frame is discarded.
REQ-003 clock  input  1  system clock; one clock domain; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line from the connector; asynchronous to clock.
REQ-006 ps2_data  input  1  raw PS/2 data line from the connector; asynchronous to clock.
REQ-007 kdone  output  1  one-cycle pulse: a new ASCII code is valid on ascii; feeds the I/O block's keyboard-done input.
REQ-008 ascii  output  8  translated key code; held until the next kdone.
REQ-009 rx_error  output  1  one-cycle pulse on a parity, start-bit, stop-bit or timeout fault.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected on the synchronized clock (old=1, new=0).
REQ-011 Receiver FSM SHALL have states IDLE, DATA, PARITY, STOP; each bit is sampled from synchronized ps2_data on a detected falling edge.
REQ-012 IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay IDLE and pulse rx_error.
REQ-013 DATA: shift 8 bits in LSB first; after the 8th -> PARITY.
REQ-014 PARITY: store the bit; -> STOP.
REQ-015 STOP: byte accepted only if stop bit = 1 and the XOR of 8 data bits and parity bit = 1 (odd parity); otherwise drop it and pulse rx_error; always -> IDLE.
REQ-016 An accepted byte SHALL reach the decoder as a one-cycle strobe in the cycle after STOP sampling.
REQ-017 A timeout counter SHALL reset on every falling edge; if it reaches CLK_HZ/1000000*TIMEOUT_US (2500 at defaults) outside IDLE, the FSM returns to IDLE, drops the partial byte and pulses rx_error.
REQ-018 Decoder byte E0 SHALL set an ext flag; F0 SHALL set a brk flag; neither produces output.
REQ-019 Any other byte SHALL clear ext and brk after it is processed.
REQ-020 Codes 12h and 59h (L/R Shift) SHALL set shift on make and clear it on break; 14h (Ctrl, either ext state) SHALL set and clear ctrl the same way; none of these produce output.
REQ-021 A break of any other code SHALL produce no output.
REQ-022 A non-extended make SHALL be translated through a 128-entry table with two columns: plain and shifted.
REQ-023 Table contents: letters a-z / A-Z; digits and US-layout symbols; 29h->20h; 5Ah->0Dh; 66h->08h; 76h->1Bh; 0Dh->09h.
REQ-024 With ctrl=1, a letter SHALL yield its code AND 1Fh (e.g. Ctrl+C -> 03h).
REQ-025 Extended makes SHALL map E0 75/72/6B/74 (up/down/left/right) -> 80h/81h/82h/83h, E0 6C/69 (home/end) -> 84h/85h, E0 71 (del) -> 7Fh, E0 5A -> 0Dh.
REQ-026 Unmapped codes (table entry 00h) and codes >= 80h other than E0/F0 SHALL produce no output and no error.
REQ-027 On a mapped make, kdone SHALL pulse exactly one cycle and ascii SHALL update in the same cycle, 1 cycle after the receiver strobe.
REQ-028 Auto-repeat makes SHALL each produce a new kdone.
REQ-029 A falling edge arriving in the same cycle as a timeout expiry SHALL win: the bit is sampled and the counter cleared.

Reset
REQ-030 Reset SHALL set: FSM to IDLE; bit count, shift register and timeout counter to 0; ext, brk, shift and ctrl to 0; kdone=0, rx_error=0, ascii=00h; synchronizer flops to 1.
REQ-031 Reset asserted mid-frame SHALL discard the frame; reception restarts with the next start bit after reset is released.

Structure
REQ-032 Shared package ps2_pkg SHALL hold the receiver state enum, the constants E0h, F0h, 12h, 59h and 14h, and the special output codes 80h-85h.
REQ-033 Sub-module ps2_rx SHALL contain the synchronizers, the receiver FSM and the timeout; the top level SHALL contain the decoder and translation table.

Verification
REQ-034 Frame 1Ch (valid parity) -> one kdone, ascii=61h; rx_error stays 0.
REQ-035 Sequence 12, 1C, F0 1C, F0 12, then 1C -> kdone with 41h, then kdone with 61h; no kdone for the break codes.
REQ-036 Sequence E0 75, E0 F0 75 -> a single kdone, ascii=80h.
REQ-037 Frame 1Ch with the parity bit inverted -> rx_error pulse, no kdone, ascii unchanged.
REQ-038 Send 5 bits, hold ps2_clk high for 2600 cycles, then a full 29h frame -> rx_error pulse, then kdone with ascii=20h.
REQ-039 Assert reset for 1 cycle after 4 data bits of a frame, then send 5Ah -> only one kdone, with ascii=0Dh.
